// File: rtl/mmio_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx_pkg
// Description : Shared definitions for the memory-mapped UART transmitter.
//               Register offsets, STATUS bit positions and the 3-bit shifter
//               state encodings.
// Revision    : 1.0  initial release
// ============================================================================
package mmio_uart_tx_pkg;

    // Register offsets inside the 8-byte window
    localparam logic [31:0] UART_TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] UART_STATUS_OFS = 32'h0000_0004;

    // STATUS bit positions
    localparam int STAT_FULL_BIT   = 0;
    localparam int STAT_EMPTY_BIT  = 1;
    localparam int STAT_ACTIVE_BIT = 2;
    localparam int STAT_OVF_BIT    = 3;
    localparam int STAT_PAR_BIT    = 4;
    localparam int STAT_CNT_LSB    = 8;
    localparam int STAT_CNT_W      = 4;

    // Shifter states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, first-word fall-through read port.
//               A simultaneous push and pop is accepted even when full.
// Ports       : clk, rst (async, active-high), i_push, i_pop, i_din,
//               o_dout, o_full, o_empty, o_count
// Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full  = (r_count == (c_AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    // When full, a push is only accepted if a pop frees the slot this cycle
    assign w_push_ok = i_push && (!o_full || i_pop);
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through the count
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped UART transmitter. Decodes core stores into a
//               TX FIFO, serialises bytes as 8N1 (or 8E1) frames on txd and
//               returns a combinational STATUS word for polling.
// Ports       : clk, rst (async, active-high), addr, wdata, we  -> inputs
//               rdata, sel, txd, busy                          -> outputs
// Config      : define UART_TX_PARITY_EN to insert an even-parity bit.
// Revision    : 1.0  initial release
// ============================================================================
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        txd,
    output logic        busy
);

    localparam int          c_CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int          c_BW          = $clog2(CLKS_PER_BIT);
    localparam int          c_CNT_BITS    = (c_CW < STAT_CNT_W) ? c_CW : STAT_CNT_W;
    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [29:0] c_TXDATA_WORD = BASE_ADDR[31:2] + UART_TXDATA_OFS[31:2];
    localparam logic [29:0] c_STATUS_WORD = BASE_ADDR[31:2] + UART_STATUS_OFS[31:2];
`ifdef UART_TX_PARITY_EN
    localparam tx_state_t   c_AFTER_DATA  = ST_PARITY;
    localparam logic        c_PAR_FLAG    = 1'b1;
`else
    localparam tx_state_t   c_AFTER_DATA  = ST_STOP;
    localparam logic        c_PAR_FLAG    = 1'b0;
`endif

    // ---------------- decode ----------------
    logic            w_txdata_hit, w_status_hit, w_push, w_pop;
    logic            w_full, w_empty, w_push_ok, w_fifo_nz_next;
    logic [7:0]      w_dout;
    logic [c_CW-1:0] w_count;
    logic            r_ovf;
    logic [31:0]     w_status;
    logic            w_unused;

    assign sel          = (addr[31:3] == BASE_ADDR[31:3]);
    assign w_txdata_hit = (addr[31:2] == c_TXDATA_WORD);
    assign w_status_hit = (addr[31:2] == c_STATUS_WORD);
    assign w_push       = w_txdata_hit && we[0];
    assign w_unused     = ^{addr[1:0], wdata[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (wdata[7:0]),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Occupancy after the coming edge, so busy can be registered
    assign w_push_ok      = w_push && (!w_full || w_pop);
    assign w_fifo_nz_next = w_push_ok || (w_count > {{(c_CW-1){1'b0}}, w_pop});

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 r_ovf <= 1'b0;
        else if (w_push && w_full && !w_pop)     r_ovf <= 1'b1;
        else if (w_status_hit && (we != 4'b0))   r_ovf <= 1'b0;
    end

    // ---------------- shifter FSM ----------------
    tx_state_t       r_state, w_state_next;
    logic [c_BW-1:0] r_baud, w_baud_next;
    logic [2:0]      r_bit_idx, w_bit_next;
    logic [7:0]      r_shift, w_shift_next;
    logic            r_txd, w_txd_next;
    logic            r_busy;
    logic            w_baud_done;
`ifdef UART_TX_PARITY_EN
    logic            r_par, w_par_next;
`endif

    assign w_baud_done = (r_baud == c_BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_next;
            r_shift   <= w_shift_next;
            r_txd     <= w_txd_next;
            r_busy    <= (w_state_next != ST_IDLE) || w_fifo_nz_next;
`ifdef UART_TX_PARITY_EN
            r_par     <= w_par_next;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_next   = r_par;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_dout;
                    w_baud_next  = '0;
                    w_state_next = ST_START;
`ifdef UART_TX_PARITY_EN
                    w_par_next   = ^w_dout;
`endif
                end
            end
            ST_START: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = ST_DATA;
                end else begin
                    w_baud_next  = r_baud + c_BW'(1);
                end
            end
            ST_DATA: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) w_state_next = c_AFTER_DATA;
                    else                   w_bit_next   = r_bit_idx + 3'd1;
                end else begin
                    w_baud_next  = r_baud + c_BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_state_next = ST_STOP;
                end else begin
                    w_baud_next  = r_baud + c_BW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    // Back-to-back: next start bit follows the stop bit directly
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_dout;
                        w_state_next = ST_START;
`ifdef UART_TX_PARITY_EN
                        w_par_next   = ^w_dout;
`endif
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud + c_BW'(1);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // txd is registered from the state being entered
        case (w_state_next)
            ST_START:  w_txd_next = 1'b0;
            ST_DATA:   w_txd_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_txd_next = w_par_next;
`endif
            default:   w_txd_next = 1'b1;
        endcase
    end

    assign txd  = r_txd;
    assign busy = r_busy;

    // ---------------- status / read mux ----------------
    always_comb begin
        w_status                                  = '0;
        w_status[STAT_FULL_BIT]                   = w_full;
        w_status[STAT_EMPTY_BIT]                  = w_empty;
        w_status[STAT_ACTIVE_BIT]                 = (r_state != ST_IDLE);
        w_status[STAT_OVF_BIT]                    = r_ovf;
        w_status[STAT_PAR_BIT]                    = c_PAR_FLAG;
        w_status[STAT_CNT_LSB +: c_CNT_BITS]      = w_count[c_CNT_BITS-1:0];
    end

    assign rdata = w_status_hit ? w_status : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart_tx
// Description : Self-checking bench for mmio_uart_tx. A queue-based model
//               predicts the txd waveform, busy, sel and rdata each cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'hFFFF0000;
`ifdef UART_TX_PARITY_EN
    localparam int   FBITS = 11;
    localparam logic PFLAG = 1'b1;
`else
    localparam int   FBITS = 10;
    localparam logic PFLAG = 1'b0;
`endif

    logic        clk, rst;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  we;
    logic        sel, txd, busy;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .rdata (rdata),
        .sel   (sel),
        .txd   (txd),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: line holds the remaining per-cycle txd levels of the frame on
    // the wire; mq holds bytes waiting in the FIFO.
    bit         line[$];
    logic [7:0] mq[$];
    bit         ovf;

    function automatic void model_reset();
        line.delete();
        mq.delete();
        ovf = 1'b0;
    endfunction

    function automatic void load(input logic [7:0] b);
        for (int i = 0; i < FBITS; i++) begin
            bit v;
            if (i == 0)                       v = 1'b0;
            else if (i <= 8)                  v = b[i-1];
            else if (i == 9 && FBITS == 11)   v = ^b;
            else                              v = 1'b1;
            repeat (CPB) line.push_back(v);
        end
    endfunction

    function automatic void model_edge(input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] w);
        logic [29:0] tx_w, st_w;
        tx_w = BASE[31:2];
        st_w = tx_w + 30'd1;
        if (line.size() > 0) begin
            void'(line.pop_front());
            if (line.size() == 0 && mq.size() > 0) load(mq.pop_front());
        end else if (mq.size() > 0) begin
            load(mq.pop_front());
        end
        if (a[31:2] == tx_w && w[0]) begin
            if (mq.size() < DEPTH) mq.push_back(d[7:0]);
            else                   ovf = 1'b1;
        end
        if (a[31:2] == st_w && w != 4'b0) ovf = 1'b0;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s       = '0;
        s[0]    = (mq.size() == DEPTH);
        s[1]    = (mq.size() == 0);
        s[2]    = (line.size() != 0);
        s[3]    = ovf;
        s[4]    = PFLAG;
        s[11:8] = 4'(mq.size());
        return s;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        logic [29:0] st_w;
        st_w = BASE[31:2] + 30'd1;
        return (a[31:2] == st_w) ? exp_status() : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, model the edge, check outputs at the negedge
    task automatic tick(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        logic [31:0] base_hi;
        addr  = a;
        wdata = d;
        we    = w;
        @(posedge clk);
        model_edge(a, d, w);
        @(negedge clk);
        base_hi = BASE;
        chk("txd",   {31'b0, txd},  {31'b0, (line.size() > 0) ? line[0] : 1'b1});
        chk("busy",  {31'b0, busy}, {31'b0, (line.size() > 0) || (mq.size() > 0)});
        chk("rdata", rdata, exp_rdata(a));
        chk("sel",   {31'b0, sel},  {31'b0, a[31:3] == base_hi[31:3]});
        we = 4'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(BASE + 32'h4, 32'h0, 4'b0);
    endtask

    localparam int FRAME = FBITS * CPB;

    initial begin
        rst   = 1'b1;
        addr  = BASE + 32'h4;
        wdata = 32'h0;
        we    = 4'b0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset_status", rdata, PFLAG ? 32'h12 : 32'h2);
        chk("reset_txd",    {31'b0, txd},  32'h1);
        chk("reset_busy",   {31'b0, busy}, 32'h0);
        rst = 1'b0;
        idle(2);

        // sw 0xA5 to BASE, full frame
        tick(BASE, 32'h0000_00A5, 4'b1111);
        idle(FRAME + 4);

        // sb 0x55 to BASE+3, then a non-pushing sb to BASE+0
        tick(BASE + 32'h3, 32'h0000_0055, 4'b0001);
        idle(FRAME + 4);
        tick(BASE, 32'h5500_0000, 4'b1000);
        chk("no_push_status", rdata, 32'h0);
        idle(1);
        chk("no_push_count", rdata, PFLAG ? 32'h12 : 32'h2);

        // Overflow: one byte on the wire, five more in consecutive cycles
        tick(BASE, 32'($urandom_range(0, 255)), 4'b1111);
        repeat (5) tick(BASE + 32'h3, 32'($urandom_range(0, 255)), 4'b0001);
        idle(1);
        chk("ovf_status", rdata, PFLAG ? 32'h41D : 32'h40D);
        idle(10);
        tick(BASE + 32'h4, 32'h0, 4'b1111);
        idle(1);
        chk("ovf_clear", rdata & 32'h8, 32'h0);
        idle(FRAME * (DEPTH + 1) + 4);

        // Reset during DATA bit 3 (bit 3 of the byte forced low)
        tick(BASE, 32'($urandom_range(0, 255)) & 32'hF7, 4'b1111);
        tick(BASE, 32'($urandom_range(0, 255)), 4'b1111);
        idle(16);
        rst = 1'b1;
        #1;
        chk("async_rst_txd", {31'b0, txd}, 32'h1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        chk("post_rst_status", rdata, PFLAG ? 32'h12 : 32'h2);
        idle(FRAME + 10);

        // Parity-relevant byte (3 ones)
        tick(BASE, 32'h0000_0007, 4'b1111);
        idle(FRAME + 4);

        // Randomised bus traffic across and around the window
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0)
                tick(BASE + 32'($urandom_range(0, 11)), $urandom, 4'($urandom));
            else if ($urandom_range(0, 3) == 0)
                tick($urandom, $urandom, 4'b0);
            else
                tick(BASE + 32'h4, 32'h0, 4'b0);
        end
        idle(FRAME * (DEPTH + 1) + 10);
        chk("final_idle_status", rdata & 32'hF07, 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the core's data-memory port, downstream of the processor. It decodes the core's data address, write data and byte enables, and buffers written bytes in a small FIFO. It serializes them as 8N1 frames on `txd` and returns a status word combinationally on the read-data path so the single-cycle core can poll it.

## Interface

Parameters:
- `BASE_ADDR`, 32'hFFFF0000: word-aligned base of the register window.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, minimum 2.
- `CLKS_PER_BIT`, 868: clock cycles per serial bit, minimum 2.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `addr`, in, 32: data address from the core's ALU result.
- `wdata`, in, 32: store data, byte-lane aligned (big-endian lanes: addr[1:0]=3 → bits [7:0]).
- `we`, in, 4: byte write enables; bit 3 = lane [31:24], bit 0 = lane [7:0].
- `rdata`, out, 32: combinational read data for the addressed register, 0 outside the window.
- `sel`, out, 1: combinational; high when addr[31:3] matches the window, for external read-mux steering.
- `txd`, out, 1: serial output, registered, idle high.
- `busy`, out, 1: registered; shifter active or FIFO non-empty.

## Operation

Register map, by word offset:
- 0x0 TXDATA, write-only. A push occurs when `addr[31:2]==BASE_ADDR[31:2]` and `we[0]==1`; the pushed byte is `wdata[7:0]`. This covers `sw` to BASE and `sb` to BASE+3. Other lanes are ignored. Reads return 0.
- 0x4 STATUS, read. Bit 0 = full, bit 1 = empty, bit 2 = shifter active, bit 3 = overflow (sticky), bits [11:8] = FIFO count, all other bits 0. Any write with `we!=0` clears overflow.

FIFO rules:
- A push while full with no pop in the same cycle drops the byte and sets overflow.
- A push and a pop in the same cycle are both accepted, including when full; the count is unchanged.

Shifter FSM, with bit counter 0..7 and baud counter 0..CLKS_PER_BIT-1:
- IDLE (txd=1): if the FIFO is non-empty, pop into the shift register, clear the baud counter, go to START.
- START (txd=0): after CLKS_PER_BIT cycles, go to DATA with bit index 0.
- DATA (txd=shift[0], LSB first): each CLKS_PER_BIT cycles, shift right and increment the index. After bit 7, go to STOP (or PARITY, see Configuration).
- STOP (txd=1): after CLKS_PER_BIT cycles, pop and go to START if the FIFO is non-empty (back-to-back, no idle gap), else go to IDLE.

Reads have no side effects. `rdata` is a function of `addr` and the current registers only.

## Timing

- Reset values: `txd`=1, `busy`=0, FIFO empty, overflow=0, FSM in IDLE, all counters 0. `rdata` and `sel` follow `addr` combinationally.
- A push at edge N makes STATUS reflect the new count immediately after N.
- With an empty FIFO and IDLE state, a push at edge N causes a pop at edge N+1, and `txd` falls after N+1.
- Frame length is exactly 10×CLKS_PER_BIT cycles (11× with parity).
- `busy` rises after the push edge and falls after the final stop-bit edge, when the FIFO is empty.
- Reset mid-frame: `txd` returns to 1 asynchronously, queued bytes are discarded, no partial frame resumes.
- Count width is clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.

## Configuration

- `UART_TX_PARITY_EN` defined: adds a PARITY state between DATA and STOP, lasting CLKS_PER_BIT cycles, with `txd` = XOR of the 8 data bits (even parity). STATUS bit 4 reads 1.
- Undefined: 8N1 only, no PARITY state, STATUS bit 4 reads 0.

## Structure

- Shared header (def.h style): register offsets `UART_TXDATA_OFS`/`UART_STATUS_OFS`, STATUS bit positions, FSM state encodings (IDLE/START/DATA/PARITY/STOP, 3-bit).
- One sub-module, `sync_fifo`: parameterized width/depth, push/pop/full/empty/count, with same-cycle push+pop-when-full accepted.
- Decode, status mux and FSM live in the top.

## Test plan

All scenarios use CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Reset, then read STATUS at BASE+4 → `rdata`=32'h0000_0002, `txd`=1, `busy`=0.
- `sw` 32'h0000_00A5 to BASE → `txd` low 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), high 4 cycles; `busy` low after cycle 41.
- `sb` with `we`=4'b0001, `wdata`[7:0]=8'h55 at BASE+3 → frame sent. `sb` to BASE+0 (`we`=4'b1000) → no push, count stays 0.
- Write 5 bytes in consecutive cycles while the first is not yet popped (stall the pop by asserting reset release only after the writes) → 4 queued. STATUS bit 0=1, bit 3=1, count=4. Frames follow back-to-back with no idle gap. A later write to BASE+4 clears bit 3.
- Assert `rst` during DATA bit 3 → `txd`=1 in the same cycle, STATUS=32'h2 after release, no further frames.
- With `UART_TX_PARITY_EN`, send 8'h07 → parity bit 1, frame 44 cycles.
